// File: rtl/harmonic_accum_if.sv
// Bundles the sample request, sine/scaler handshakes and sample output of harmonic_accum.
// The slave modport is the accumulator side; master is its environment.
interface harmonic_accum_if;
    logic               i_Sample_Start;
    logic [7:0]         i_Harmonic_Count;
    logic signed [15:0] i_Sine;
    logic               i_Sine_Valid;
    logic [7:0]         i_Mult;
    logic               i_Mult_Ready;
    logic               i_Comb_Muted;
    logic [7:0]         o_Harmonic;
    logic               o_Sine_Req;
    logic               o_Scale_Restart;
    logic               o_Scale_Start;
    logic signed [15:0] o_Sample;
    logic               o_Sample_Valid;
    logic               o_Busy;

    modport slave (
        input  i_Sample_Start, i_Harmonic_Count, i_Sine, i_Sine_Valid,
               i_Mult, i_Mult_Ready, i_Comb_Muted,
        output o_Harmonic, o_Sine_Req, o_Scale_Restart, o_Scale_Start,
               o_Sample, o_Sample_Valid, o_Busy
    );

    modport master (
        output i_Sample_Start, i_Harmonic_Count, i_Sine, i_Sine_Valid,
               i_Mult, i_Mult_Ready, i_Comb_Muted,
        input  o_Harmonic, o_Sine_Req, o_Scale_Restart, o_Scale_Start,
               o_Sample, o_Sample_Valid, o_Busy
    );
endinterface

// File: rtl/harmonic_accum.sv
// Sums sine x level products over a programmable number of harmonics into one
// saturated 16-bit output sample, pacing the sine source and the scaling stage.
module harmonic_accum (
    input  logic            i_Clock,
    input  logic            i_Reset_n,
    harmonic_accum_if.slave bus
);
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned PROD_W = 24;
    localparam int unsigned SMP_W  = 16;
    localparam int unsigned HRM_W  = 8;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RESTART = 3'd1;
    localparam logic [2:0] FETCH   = 3'd2;
    localparam logic [2:0] MAC     = 3'd3;
    localparam logic [2:0] SETTLE  = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]               state, state_nx;
    logic [HRM_W-1:0]         count_q, count_nx, harm_nx, harm_inc;
    logic signed [SMP_W-1:0]  sine_q, sine_nx;
    logic [HRM_W-1:0]         mult_q, mult_nx;
    logic                     muted_q, muted_nx;
    logic signed [ACC_W-1:0]  acc_q, acc_nx, shifted;
    logic signed [PROD_W-1:0] sine_ext, mult_ext, prod;
    logic signed [SMP_W-1:0]  sample_nx, sat;
    logic                     sine_req_nx, restart_nx, start_nx, valid_nx, busy_nx;

    // Multiply-accumulate datapath and output saturation
    always_comb begin
        sine_ext = {{(PROD_W-SMP_W){sine_q[SMP_W-1]}}, sine_q};
        mult_ext = {{(PROD_W-HRM_W){1'b0}}, mult_q};
        prod     = muted_q ? '0 : sine_ext * mult_ext;
        shifted  = acc_q >>> 8;
        harm_inc = bus.o_Harmonic + HRM_W'(1);
        if (shifted > 32'sd32767)
            sat = 16'sh7FFF;
        else if (shifted < -32'sd32768)
            sat = 16'sh8000;
        else
            sat = shifted[SMP_W-1:0];
    end

    always_comb begin
        state_nx    = state;
        count_nx    = count_q;
        harm_nx     = bus.o_Harmonic;
        sine_nx     = sine_q;
        mult_nx     = mult_q;
        muted_nx    = muted_q;
        acc_nx      = acc_q;
        sample_nx   = bus.o_Sample;
        sine_req_nx = 1'b0;
        restart_nx  = 1'b0;
        start_nx    = 1'b0;
        valid_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_Sample_Start) begin
                    count_nx = bus.i_Harmonic_Count;
                    acc_nx   = '0;
                    harm_nx  = '0;
                    // A zero count never touches the scaler or the sine source
                    if (bus.i_Harmonic_Count == '0) begin
                        state_nx = DONE;
                    end else begin
                        restart_nx = 1'b1;
                        state_nx   = RESTART;
                    end
                end
            end
            RESTART: begin
                sine_req_nx = 1'b1;
                state_nx    = FETCH;
            end
            FETCH: begin
                sine_req_nx = 1'b1;
                if (bus.i_Sine_Valid && bus.i_Mult_Ready) begin
                    sine_nx     = bus.i_Sine;
                    mult_nx     = bus.i_Mult;
                    muted_nx    = bus.i_Comb_Muted;
                    sine_req_nx = 1'b0;
                    state_nx    = MAC;
                end
            end
            MAC: begin
                acc_nx  = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                harm_nx = harm_inc;
                if (harm_inc == count_q) begin
                    state_nx = DONE;
                end else begin
                    start_nx = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                // Scaler drops ready for one cycle after a start pulse
                sine_req_nx = 1'b1;
                state_nx    = FETCH;
            end
            DONE: begin
                sample_nx = sat;
                valid_nx  = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            count_q             <= '0;
            sine_q              <= '0;
            mult_q              <= '0;
            muted_q             <= 1'b0;
            acc_q               <= '0;
            bus.o_Harmonic      <= '0;
            bus.o_Sine_Req      <= 1'b0;
            bus.o_Scale_Restart <= 1'b0;
            bus.o_Scale_Start   <= 1'b0;
            bus.o_Sample        <= '0;
            bus.o_Sample_Valid  <= 1'b0;
            bus.o_Busy          <= 1'b0;
        end else begin
            count_q             <= count_nx;
            sine_q              <= sine_nx;
            mult_q              <= mult_nx;
            muted_q             <= muted_nx;
            acc_q               <= acc_nx;
            bus.o_Harmonic      <= harm_nx;
            bus.o_Sine_Req      <= sine_req_nx;
            bus.o_Scale_Restart <= restart_nx;
            bus.o_Scale_Start   <= start_nx;
            bus.o_Sample        <= sample_nx;
            bus.o_Sample_Valid  <= valid_nx;
            bus.o_Busy          <= busy_nx;
        end
    end
endmodule

// File: tb/tb_harmonic_accum.sv
// Directed bench for harmonic_accum: drives sine/level tables per harmonic and
// checks sums, saturation, pulse counts, latency, stalls and async reset.
module tb_harmonic_accum;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    harmonic_accum_if bus();

    harmonic_accum dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [15:0] sine_tab [256];
    logic [7:0]         mult_tab [256];
    logic               mute_tab [256];

    int         n_restart, n_sstart, n_req, n_both, lat;
    logic       timeout;
    logic [7:0] harm_q [$];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic signed [15:0] s, input logic [7:0] m);
        for (int i = 0; i < 256; i++) begin
            sine_tab[i] = s;
            mult_tab[i] = m;
            mute_tab[i] = 1'b0;
        end
    endtask

    // Start a sample and serve the sine source / scaler until o_Sample_Valid.
    // stall: FETCH cycles with ready held low; poke_at: cycle of a stray start pulse.
    task automatic run_sample(input logic [7:0] cnt, input int stall, input int poke_at);
        int st;
        st = stall;
        n_restart = 0; n_sstart = 0; n_req = 0; n_both = 0;
        timeout = 1'b0;
        harm_q.delete();
        bus.i_Harmonic_Count = cnt;
        bus.i_Sample_Start   = 1'b1;
        @(posedge clk); #1;
        bus.i_Sample_Start = 1'b0;
        lat = 1;
        forever begin
            if (bus.o_Scale_Restart) n_restart++;
            if (bus.o_Scale_Start)   n_sstart++;
            if (bus.o_Scale_Restart && bus.o_Scale_Start) n_both++;
            if (bus.o_Sine_Req)      n_req++;
            if (bus.o_Sample_Valid) break;
            if (lat >= 2000) begin
                timeout = 1'b1;
                break;
            end
            bus.i_Sine         = sine_tab[bus.o_Harmonic];
            bus.i_Mult         = mult_tab[bus.o_Harmonic];
            bus.i_Comb_Muted   = mute_tab[bus.o_Harmonic];
            bus.i_Sine_Valid   = 1'b1;
            bus.i_Mult_Ready   = !(bus.o_Sine_Req && st > 0);
            if (bus.o_Sine_Req && st > 0) st--;
            if (bus.o_Sine_Req && bus.i_Mult_Ready) harm_q.push_back(bus.o_Harmonic);
            bus.i_Sample_Start = (lat == poke_at);
            @(posedge clk); #1;
            lat++;
        end
        bus.i_Sample_Start = 1'b0;
        chk("timeout", timeout, 0);
    endtask

    initial begin
        rst_n                = 1'b0;
        bus.i_Sample_Start   = 1'b0;
        bus.i_Harmonic_Count = '0;
        bus.i_Sine           = '0;
        bus.i_Sine_Valid     = 1'b0;
        bus.i_Mult           = '0;
        bus.i_Mult_Ready     = 1'b0;
        bus.i_Comb_Muted     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sample", bus.o_Sample, 0);
        chk("rst_busy", bus.o_Busy, 0);
        chk("rst_valid", bus.o_Sample_Valid, 0);
        chk("rst_harm", bus.o_Harmonic, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single harmonic: 1000*255 = 255000, >>>8 = 996
        fill(16'sd1000, 8'd255);
        run_sample(8'd1, 0, -1);
        chk("c1_sample", bus.o_Sample, 996);
        chk("c1_restart", n_restart, 1);
        chk("c1_sstart", n_sstart, 0);
        chk("c1_latency", lat, 5);
        @(posedge clk); #1;
        chk("c1_valid_pulse", bus.o_Sample_Valid, 0);
        chk("c1_idle", bus.o_Busy, 0);

        // Four harmonics, harmonic index 2 muted: 16384*(200+150+50) = 6553600, >>>8 = 25600
        fill(16'sd16384, 8'd0);
        mult_tab[0] = 8'd200; mult_tab[1] = 8'd150; mult_tab[2] = 8'd100; mult_tab[3] = 8'd50;
        mute_tab[2] = 1'b1;
        run_sample(8'd4, 0, -1);
        chk("c4_sample", bus.o_Sample, 25600);
        chk("c4_sstart", n_sstart, 3);
        chk("c4_restart", n_restart, 1);
        chk("c4_both", n_both, 0);
        chk("c4_latency", lat, 14);
        chk("c4_nharm", harm_q.size(), 4);
        for (int i = 0; i < 4 && i < harm_q.size(); i++)
            chk("c4_harm_seq", harm_q[i], i);

        // Positive and negative saturation over 255 harmonics
        fill(16'sd32767, 8'd255);
        run_sample(8'd255, 0, -1);
        chk("sat_pos", bus.o_Sample, 32767);
        chk("sat_pos_latency", lat, 767);
        chk("sat_pos_sstart", n_sstart, 254);
        chk("sat_pos_both", n_both, 0);
        fill(-16'sd32768, 8'd255);
        run_sample(8'd255, 0, -1);
        chk("sat_neg", bus.o_Sample, -32768);

        // Zero count goes straight to an all-zero result
        run_sample(8'd0, 0, -1);
        chk("c0_sample", bus.o_Sample, 0);
        chk("c0_restart", n_restart, 0);
        chk("c0_sstart", n_sstart, 0);
        chk("c0_req", n_req, 0);
        chk("c0_latency", lat, 2);

        // Ready stall of 5 FETCH cycles plus a stray start while busy:
        // 1000*10 + (-2000)*20 = -30000, >>>8 = -118
        fill(16'sd0, 8'd0);
        sine_tab[0] = 16'sd1000;  mult_tab[0] = 8'd10;
        sine_tab[1] = -16'sd2000; mult_tab[1] = 8'd20;
        run_sample(8'd2, 5, 4);
        chk("stall_sample", bus.o_Sample, -118);
        chk("stall_req_cycles", n_req, 7);
        chk("stall_latency", lat, 13);
        chk("stall_nharm", harm_q.size(), 2);
        repeat (3) @(posedge clk);
        #1;
        chk("stray_start_busy", bus.o_Busy, 0);
        chk("stray_start_valid", bus.o_Sample_Valid, 0);

        // Reset asserted while in MAC of harmonic 2
        fill(16'sd1000, 8'd255);
        bus.i_Harmonic_Count = 8'd4;
        bus.i_Sample_Start   = 1'b1;
        bus.i_Sine_Valid     = 1'b1;
        bus.i_Mult_Ready     = 1'b1;
        @(posedge clk); #1;
        bus.i_Sample_Start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.o_Sine_Req && bus.o_Harmonic == 8'd2) break;
            @(posedge clk); #1;
        end
        chk("pre_rst_fetch2", bus.o_Sine_Req, 1);
        @(posedge clk); #1;
        chk("pre_rst_busy", bus.o_Busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_harm", bus.o_Harmonic, 0);
        chk("arst_sample", bus.o_Sample, 0);
        chk("arst_busy", bus.o_Busy, 0);
        chk("arst_req", bus.o_Sine_Req, 0);
        chk("arst_sstart", bus.o_Scale_Start, 0);
        chk("arst_restart", bus.o_Scale_Restart, 0);
        chk("arst_valid", bus.o_Sample_Valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_sample(8'd1, 0, -1);
        chk("post_rst_sample", bus.o_Sample, 996);
        chk("post_rst_latency", lat, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
